// File: rtl/sb_fanout_fork.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fanout_fork
//  Description : Eager ready/valid fork for switch-box track fanout. One
//                upstream word stream is held in a 2-entry buffer and offered
//                to up to NUM_OUT consumer branches. Each branch handshakes
//                independently; the head word retires once every enabled
//                branch has taken it. in_ready is derived from registered
//                occupancy only, so no ready path runs combinationally from
//                the branches back to the upstream producer.
//
//  Ports       : CLK           clock, rising edge
//                ASYNCRESET    asynchronous active-high reset
//                config_en     per-branch enable (route select)
//                in_data       upstream word
//                in_valid      upstream valid
//                in_ready      upstream ready
//                out_data      head word, shared by all branches
//                out_valid     per-branch valid
//                out_ready     per-branch ready
//                stall_cycles  saturating count of head-blocked cycles
//                stall_clr     synchronous clear of stall_cycles
//
//  Revision    : 1.0  initial release
// ============================================================================
module sb_fanout_fork #(
  parameter int WIDTH   = 16,
  parameter int NUM_OUT = 7,
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic [NUM_OUT-1:0] config_en,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [STALL_W-1:0] stall_cycles,
  input  logic               stall_clr
);

  localparam logic [1:0] c_CNT_EMPTY = 2'd0;
  localparam logic [1:0] c_CNT_FULL  = 2'd2;

  // Storage and occupancy
  logic [WIDTH-1:0]   r_mem [2];
  logic               r_head;
  logic               r_tail;
  logic [1:0]         r_count;
  logic [NUM_OUT-1:0] r_served;
  logic [STALL_W-1:0] r_stall;

  // Handshake terms
  logic               w_nonempty;
  logic               w_push;
  logic               w_pop;
  logic [NUM_OUT-1:0] w_fire;
  logic [NUM_OUT-1:0] w_done;
  logic               w_all_done;

  assign w_nonempty = (r_count != c_CNT_EMPTY);

  // Reset is folded in so upstream never sees ready while the block is
  // being held in reset.
  assign in_ready   = (r_count != c_CNT_FULL) & ~ASYNCRESET;
  assign w_push     = in_valid & in_ready;

  assign out_data   = r_mem[r_head];
  assign out_valid  = {NUM_OUT{w_nonempty}} & config_en & ~r_served;
  assign w_fire     = out_valid & out_ready;

  // A branch no longer holds up the head when it is disabled, has already
  // taken the word, or is taking it this cycle. Disabled branches are
  // masked out here, so stale served bits on them never block retirement.
  assign w_done     = ~config_en | r_served | out_ready;
  assign w_all_done = &w_done;
  assign w_pop      = w_nonempty & w_all_done;

  // Entry storage carries no reset; contents are qualified by r_count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_tail] <= in_data;
    end
  end

  // Pointers and occupancy. 1-bit pointers wrap 1 -> 0 on increment.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= c_CNT_EMPTY;
    end else begin
      if (w_push) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Served tracking: a branch that fires is masked until the head retires,
  // which guarantees each branch sees each word exactly once.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_served <= '0;
    end else if (w_pop) begin
      r_served <= '0;
    end else if (w_nonempty) begin
      r_served <= r_served | w_fire;
    end
  end

  // Stall counter: counts cycles where a word is held but cannot retire.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_stall <= '0;
    end else if (stall_clr) begin
      r_stall <= '0;
    end else if (w_nonempty && !w_pop && !(&r_stall)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_sb_fanout_fork.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sb_fanout_fork
//  Description : Self-checking bench for sb_fanout_fork. A queue-based model
//                of the fork predicts valid/ready/data/stall every cycle;
//                directed scenarios add hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sb_fanout_fork;

  localparam int W  = 16;
  localparam int N  = 7;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  config_en;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [SW-1:0] stall_cycles;
  logic          stall_clr;

  sb_fanout_fork #(.WIDTH(W), .NUM_OUT(N), .STALL_W(SW)) dut (
    .CLK          (clk),
    .ASYNCRESET   (rst),
    .config_en    (config_en),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .stall_cycles (stall_cycles),
    .stall_clr    (stall_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mq[$];
  bit   [N-1:0] mserved;
  int           mstall;
  int           fires[N];
  int           aaaa_b0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mserved = '0;
      mstall  = 0;
    end else begin
      logic [N-1:0] ev;
      bit           er;
      bit           pu;
      bit           po;
      bit           ad;
      ev = '0;
      for (int i = 0; i < N; i++)
        ev[i] = (mq.size() != 0) && config_en[i] && !mserved[i];
      er = (mq.size() < 2);
      chk("out_valid", {25'd0, out_valid}, {25'd0, ev});
      chk("in_ready", {31'd0, in_ready}, {31'd0, er});
      chk("stall_cycles", {28'd0, stall_cycles}, mstall);
      if (mq.size() != 0) chk("out_data", {16'd0, out_data}, {16'd0, mq[0]});

      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          fires[i]++;
          if (i == 0 && out_data == 16'hAAAA) aaaa_b0++;
        end
      end

      // Advance: a head word leaves once every enabled branch has it.
      pu = in_valid && er;
      ad = 1'b1;
      for (int i = 0; i < N; i++)
        if (config_en[i] && !mserved[i] && !out_ready[i]) ad = 1'b0;
      po = (mq.size() != 0) && ad;
      if (stall_clr) mstall = 0;
      else if (mq.size() != 0 && !po && mstall < (1 << SW) - 1) mstall++;
      if (po) mserved = '0;
      else if (mq.size() != 0) mserved = mserved | (ev & out_ready);
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic clr_fires();
    for (int i = 0; i < N; i++) fires[i] = 0;
    aaaa_b0 = 0;
  endtask

  initial begin
    rst = 1'b1; config_en = '0; in_data = '0; in_valid = 1'b0;
    out_ready = '0; stall_clr = 1'b0;
    clr_fires();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {25'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_stall", {28'd0, stall_cycles}, 32'd0);

    // Streaming to branches 0 and 2
    config_en = 7'b0000101; out_ready = '1; stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0; clr_fires();
    for (int i = 1; i <= 16; i++) push(i[W-1:0]);
    repeat (3) cyc();
    chk("stream_stall", {28'd0, stall_cycles}, 32'd0);
    chk("stream_b0", fires[0], 32'd16);
    chk("stream_b1", fires[1], 32'd0);
    chk("stream_b2", fires[2], 32'd16);

    // Skewed ready
    config_en = 7'b0000011; out_ready = 7'b0000001; stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0; clr_fires();
    fork
      begin push(16'hAAAA); push(16'hBBBB); push(16'hCCCC); end
      begin repeat (4) @(posedge clk); #1; out_ready[1] = 1'b1; end
    join
    repeat (4) cyc();
    chk("skew_stall", {28'd0, stall_cycles}, 32'd3);
    chk("skew_b0", fires[0], 32'd3);
    chk("skew_b1", fires[1], 32'd3);
    chk("skew_aaaa_once", aaaa_b0, 32'd1);

    // Sink mode
    config_en = '0; out_ready = '0; clr_fires();
    for (int i = 0; i < 5; i++) push(W'($urandom));
    repeat (3) cyc();
    chk("sink_fires", fires[0] + fires[1] + fires[2] + fires[3] + fires[4] + fires[5] + fires[6], 32'd0);
    chk("sink_in_ready", {31'd0, in_ready}, 32'd1);

    // Mid-flight config change
    config_en = 7'b0000011; out_ready = 7'b0000001; stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0; clr_fires();
    push(16'h1234);
    cyc();
    config_en = 7'b0000001;
    repeat (2) cyc();
    chk("mid_stall", {28'd0, stall_cycles}, 32'd1);
    chk("mid_b0", fires[0], 32'd1);
    chk("mid_b1", fires[1], 32'd0);

    // Stall saturation and clear
    config_en = 7'b0000011; out_ready = '0; stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0;
    push(16'h5555);
    repeat (20) cyc();
    chk("sat_stall", {28'd0, stall_cycles}, 32'd15);
    stall_clr = 1'b1;
    cyc(); stall_clr = 1'b0;
    chk("clr_stall", {28'd0, stall_cycles}, 32'd0);
    cyc();
    chk("resume_stall", {28'd0, stall_cycles}, 32'd1);
    out_ready = '1;
    repeat (3) cyc();

    // Randomised traffic
    config_en = 7'b1011011;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      out_ready = N'($urandom | $urandom);
      if ($urandom_range(39) == 0) config_en = N'($urandom);
      stall_clr = ($urandom_range(24) == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = '1; stall_clr = 1'b0;
    repeat (4) cyc();

    // Asynchronous reset mid-cycle while full
    config_en = 7'b0000001; out_ready = '0;
    push(16'h0101); push(16'h0202);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {25'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {25'd0, out_valid}, 32'd0);
    out_ready = '1;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sb_fanout_fork.md
# sb_fanout_fork

Eager ready/valid fork for switch-box track fanout. It accepts one word stream from a track register and drives it to up to NUM_OUT consumer branches. Each branch completes its handshake independently. A word retires only when every enabled branch has taken it. The block combines a 2-entry buffer with per-branch "served" tracking, and computes the fanout ready-merge term internally so that upstream sees a registered-state in_ready.

## Interface
Parameters:
- WIDTH, 16, data word width.
- NUM_OUT, 7, number of fanout branches (1..16).
- STALL_W, 16, width of the stall counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESET  input  1  reset; asynchronous, active-high.
- config_en  input  NUM_OUT  per-branch enable. A branch is enabled when its route-select bit is set. Static during traffic.
- in_data  input  WIDTH  upstream word.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready.
- out_data  output  WIDTH  head word, shared by all branches.
- out_valid  output  NUM_OUT  per-branch valid.
- out_ready  input  NUM_OUT  per-branch ready.
- stall_cycles  output  STALL_W  saturating count of head-blocked cycles.
- stall_clr  input  1  synchronous clear of stall_cycles.

## Operation
- **Buffer.** 2-entry circular FIFO with 1-bit head/tail pointers and a count of 0..2. in_ready = (count != 2) & ~ASYNCRESET.
- **Push.** Occurs when push = in_valid & in_ready. in_data is written at tail and tail advances.
- **Branch valid.** out_valid[i] = (count != 0) & config_en[i] & ~served[i].
- **Output data.** out_data = entry[head]. The value is don't-care when count == 0; implementations drive the stale entry.
- **Branch fire.** fire[i] = out_valid[i] & out_ready[i].
- **Done term.** done[i] = ~config_en[i] | served[i] | out_ready[i]. Define all_done = AND of done[i] over all branches.
- **Pop.** Occurs when pop = (count != 0) & all_done. Head advances and all served bits clear.
- **Served tracking without pop.** If count != 0 and no pop, served[i] <= served[i] | fire[i].
- **Count update.**
  - Push only: count + 1.
  - Pop only: count − 1.
  - Both: count unchanged.
- **All branches disabled** (config_en == 0). Every held word pops on the cycle after it is pushed, acting as a sink. Every out_valid stays 0.
- **Served bits of disabled branches.** These are ignored by all_done.
  - If config_en changes while count != 0, the head retires once the remaining enabled branches are done.
  - No word is ever delivered twice to the same branch.
- **Stall counter.**
  - Increments when count != 0 & ~pop, saturating at all ones.
  - stall_clr has priority and sets it to 0 on the next edge.

## Timing
- **Reset values** (asynchronous, while ASYNCRESET is high):
  - count = 0, head = 0, tail = 0, served = 0, stall_cycles = 0.
  - out_valid = 0 and in_ready = 0.
  - Entry storage is not reset.
- **After reset deasserts.** in_ready = 1 in the same cycle.
- **Latency.** A word pushed on edge t gives out_valid at cycle t+1, which is combinational from registered state.
- **Throughput.** 1 word/cycle when all enabled branches are ready.
  - in_ready depends only on count, never on out_ready, so there is no combinational ready path upstream.
  - Back-to-back flow holds count at 1 with simultaneous push and pop.
- **Full buffer.** At count == 2, in_ready = 0. A pop in that cycle does not allow a same-cycle push; in_ready returns to 1 the next cycle.
- **Empty buffer.** At count == 0, pop = 0 regardless of out_ready, and served stays 0.
- **Branch handshake rule.** A branch that fires has its out_valid drop on the next cycle until the head retires.
  - Other branches keep valid asserted.
  - A branch's out_valid never drops without that branch having fired, except by reset.
- **Pointer wrap.** The 1-bit pointers wrap from 1 to 0 naturally.
- **Reset mid-operation.**
  - All held words are discarded and served bits are cleared.
  - Partially delivered words are not replayed.

## Test plan
- **Reset.** Assert ASYNCRESET mid-cycle with count = 2 → out_valid = 0 and in_ready = 0 immediately; count = 0 after release; in_ready = 1 in the first cycle after release.
- **Streaming.** config_en = 7'b0000101, all ready high, push 0x0001..0x0010 back-to-back → branches 0 and 2 each receive 16 words in order at 1/cycle; stall_cycles = 0; out_valid[1] never asserted.
- **Skewed ready.** config_en = 7'b0000011, out_ready[0] = 1, out_ready[1] low for 3 cycles then high; push 0xAAAA, 0xBBBB, 0xCCCC →
  - Branch 0 gets 0xAAAA exactly once.
  - in_ready drops after 2 accepted words.
  - 0xAAAA retires when branch 1 fires.
  - stall_cycles = 3.
  - All three words reach both branches in order.
- **Sink mode.** config_en = 0, push 5 words → all accepted with in_ready high except at most transient full; no out_valid asserted; count returns to 0.
- **Mid-flight config change.** config_en changes from 7'b0000011 to 7'b0000001 after branch 0 has fired on the head while branch 1 is stalled → head retires the next cycle; branch 0 does not see the word again.
- **Stall counter saturation and clear.** STALL_W = 4, hold all ready low for 20 cycles with count != 0 → stall_cycles saturates at 15. Pulse stall_clr → 0 on the next edge, then increments resume.
